// File: rtl/ghost_move_scheduler.sv
// Scans the four neighbour tiles of every ghost once per game tick through a
// single tilemap read port and hands each ghost its movable mask in turn.
module ghost_move_scheduler #(
  parameter int NUM_GHOSTS = 4,
  parameter int SPEED      = 5,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int TILE       = 20,
  parameter int BX0        = 0,
  parameter int BX1        = 620,
  parameter int BY0        = 0,
  parameter int BY1        = 460
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NUM_GHOSTS*10-1:0] ghost_x_flat,
  input  logic [NUM_GHOSTS*9-1:0]  ghost_y_flat,
  output logic                    tile_rd,
  output logic [9:0]              tile_addr,
  input  logic                    tile_wall,
  output logic                    step_valid,
  output logic [1:0]              step_ghost,
  output logic [3:0]              step_movable,
  output logic                    busy,
  output logic                    overrun
);

  localparam int MAXG = 4;
  localparam int XW   = 10 * MAXG;
  localparam int YW   = 9 * MAXG;

  typedef enum logic [1:0] {IDLE, QUERY, CAPTURE, REPORT} state_t;

  state_t      state;
  logic [1:0]  g;
  logic [1:0]  d;
  logic [3:0]  mask;
  logic        inb_q;
  logic [9:0]  snap_x [MAXG];
  logic [8:0]  snap_y [MAXG];

  logic [XW-1:0] x_pad;
  logic [YW-1:0] y_pad;
  logic          last_ghost;

  logic          enter_query;
  logic [9:0]    q_x;
  logic [8:0]    q_y;
  logic [1:0]    q_d;
  int            nx;
  int            ny;
  logic          in_bounds;
  logic [9:0]    q_addr;

  assign x_pad      = XW'(ghost_x_flat);
  assign y_pad      = YW'(ghost_y_flat);
  assign last_ghost = (g == 2'(NUM_GHOSTS - 1));

  // Work out the lookup for the next QUERY cycle one edge early so that
  // tile_rd and tile_addr leave the FSM as plain registers.
  always_comb begin
    enter_query = 1'b0;
    q_x         = snap_x[g];
    q_y         = snap_y[g];
    q_d         = d + 2'd1;
    case (state)
      IDLE: begin
        if (tick) begin
          enter_query = 1'b1;
          q_x         = x_pad[9:0];
          q_y         = y_pad[8:0];
          q_d         = 2'd0;
        end
      end
      CAPTURE: begin
        if (d != 2'd3) enter_query = 1'b1;
      end
      REPORT: begin
        if (!last_ghost) begin
          enter_query = 1'b1;
          q_x         = snap_x[g + 2'd1];
          q_y         = snap_y[g + 2'd1];
          q_d         = 2'd0;
        end
      end
      default: ;
    endcase

    // Signed arithmetic so a step off the top/left edge goes negative.
    nx = int'(q_x);
    ny = int'(q_y);
    case (q_d)
      2'd0:    ny = ny - SPEED;
      2'd1:    ny = ny + SPEED;
      2'd2:    nx = nx - SPEED;
      default: nx = nx + SPEED;
    endcase

    in_bounds = (nx >= BX0) && (nx <= BX1) && (ny >= BY0) && (ny <= BY1);
    q_addr    = 10'((WIDTH / TILE) * (ny / TILE) + nx / TILE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      g            <= 2'd0;
      d            <= 2'd0;
      mask         <= 4'd0;
      inb_q        <= 1'b0;
      tile_rd      <= 1'b0;
      tile_addr    <= 10'd0;
      step_valid   <= 1'b0;
      step_ghost   <= 2'd0;
      step_movable <= 4'd0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < MAXG; i++) begin
        snap_x[i] <= 10'd0;
        snap_y[i] <= 9'd0;
      end
    end else begin
      tile_rd    <= 1'b0;
      step_valid <= 1'b0;
      overrun    <= tick && (state != IDLE);

      if (enter_query) begin
        d       <= q_d;
        inb_q   <= in_bounds;
        tile_rd <= in_bounds;
        if (in_bounds) tile_addr <= q_addr;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < MAXG; i++) begin
              snap_x[i] <= x_pad[10*i +: 10];
              snap_y[i] <= y_pad[9*i +: 9];
            end
            g     <= 2'd0;
            busy  <= 1'b1;
            state <= QUERY;
          end
        end
        QUERY: state <= CAPTURE;
        CAPTURE: begin
          mask[d] <= inb_q & ~tile_wall;
          if (d == 2'd3) begin
            step_valid   <= 1'b1;
            step_ghost   <= g;
            step_movable <= {inb_q & ~tile_wall, mask[2:0]};
            state        <= REPORT;
          end else begin
            state <= QUERY;
          end
        end
        REPORT: begin
          mask <= 4'd0;
          if (last_ghost) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            g     <= g + 2'd1;
            state <= QUERY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Directed bench for ghost_move_scheduler: four ghosts, a wall-map model with
// one-cycle read latency, overrun ticks, a mid-scan reset and a walled rescan.
module tb_ghost_move_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [39:0] ghost_x_flat = '0;
  logic [35:0] ghost_y_flat = '0;
  logic        tile_rd;
  logic [9:0]  tile_addr;
  logic        tile_wall = 1'b0;
  logic        step_valid;
  logic [1:0]  step_ghost;
  logic [3:0]  step_movable;
  logic        busy;
  logic        overrun;

  logic [1023:0] wall_map = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int rd_m[$], rd_a[$], sv_m[$], sv_g[$], sv_k[$], ov_m[$];
  int exp_rm[$], exp_ra[$], exp_sm[$], exp_sg[$], exp_sk[$], exp_ov[$];
  int busy_at[64];
  int addr_at[64];

  ghost_move_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .ghost_x_flat (ghost_x_flat),
    .ghost_y_flat (ghost_y_flat),
    .tile_rd      (tile_rd),
    .tile_addr    (tile_addr),
    .tile_wall    (tile_wall),
    .step_valid   (step_valid),
    .step_ghost   (step_ghost),
    .step_movable (step_movable),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Tilemap model: data one cycle after a read, junk (wall) when not read.
  always @(posedge clk) tile_wall <= tile_rd ? wall_map[tile_addr] : 1'b1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic set_ghost(input int gi, input int x, input int y);
    ghost_x_flat[10*gi +: 10] = 10'(x);
    ghost_y_flat[9*gi +: 9]   = 9'(y);
  endtask

  function automatic int all_outputs();
    return int'({tile_rd, tile_addr, step_valid, step_ghost, step_movable, busy, overrun});
  endfunction

  // Raise tick for edge k, then log outputs in the cycle after each edge k+m-1
  // under index m; tick_plan[m] is the tick level for edge k+m.
  task automatic applyStimulus(input int ncyc, input logic [63:0] tick_plan,
                               input int chg_at, input int rst_at);
    rd_m.delete(); rd_a.delete(); sv_m.delete(); sv_g.delete(); sv_k.delete(); ov_m.delete();
    tick = 1'b1;
    for (int m = 1; m <= ncyc; m++) begin
      @(posedge clk);
      @(negedge clk);
      if (tile_rd) begin
        rd_m.push_back(m);
        rd_a.push_back(int'(tile_addr));
      end
      if (step_valid) begin
        sv_m.push_back(m);
        sv_g.push_back(int'(step_ghost));
        sv_k.push_back(int'(step_movable));
      end
      if (overrun) ov_m.push_back(m);
      busy_at[m] = int'(busy);
      addr_at[m] = int'(tile_addr);
      tick = tick_plan[m];
      if (m == chg_at) set_ghost(0, 400, 100);
      if (m == rst_at) begin
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_scan_outputs", all_outputs(), 0);
      end
    end
    tick = 1'b0;
  endtask

  task automatic check_logs(input string tag);
    checkOutput({tag, "_rd_count"}, rd_m.size(), exp_rm.size());
    foreach (exp_rm[i]) begin
      checkOutput($sformatf("%s_rd%0d_cycle", tag, i), (i < rd_m.size()) ? rd_m[i] : -1, exp_rm[i]);
      checkOutput($sformatf("%s_rd%0d_addr", tag, i), (i < rd_a.size()) ? rd_a[i] : -1, exp_ra[i]);
    end
    checkOutput({tag, "_step_count"}, sv_m.size(), exp_sm.size());
    foreach (exp_sm[i]) begin
      checkOutput($sformatf("%s_step%0d_cycle", tag, i), (i < sv_m.size()) ? sv_m[i] : -1, exp_sm[i]);
      checkOutput($sformatf("%s_step%0d_ghost", tag, i), (i < sv_g.size()) ? sv_g[i] : -1, exp_sg[i]);
      checkOutput($sformatf("%s_step%0d_mask", tag, i), (i < sv_k.size()) ? sv_k[i] : -1, exp_sk[i]);
    end
    checkOutput({tag, "_overrun_count"}, ov_m.size(), exp_ov.size());
    foreach (exp_ov[i])
      checkOutput($sformatf("%s_overrun%0d_cycle", tag, i), (i < ov_m.size()) ? ov_m[i] : -1, exp_ov[i]);
  endtask

  initial begin
    int busy_cnt;
    int act;

    set_ghost(0, 100, 100);
    set_ghost(1, 0, 0);
    set_ghost(2, 620, 460);
    set_ghost(3, 300, 200);

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", all_outputs(), 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_outputs", all_outputs(), 0);

    // Scan 1 on an empty map, ghost 0 x moved at k+3, ticks at k+5/k+36/k+37,
    // the k+37 tick starts scan 2 which is aborted by reset at k+49.
    $display("[TB] scan 1: empty map, overruns, restart, mid-scan reset");
    applyStimulus(50, (64'd1 << 5) | (64'd1 << 36) | (64'd1 << 37), 3, 49);
    exp_rm = '{1, 3, 5, 7, 12, 16, 19, 23, 28, 30, 32, 34, 38, 40, 42, 44, 49};
    exp_ra = '{133, 165, 164, 165, 0, 0, 735, 766, 303, 335, 334, 335, 148, 180, 179, 180, 0};
    exp_sm = '{9, 18, 27, 36, 46};
    exp_sg = '{0, 1, 2, 3, 0};
    exp_sk = '{15, 10, 5, 15, 15};
    exp_ov = '{6, 37};
    check_logs("scan1");

    busy_cnt = 0;
    for (int m = 1; m <= 36; m++) busy_cnt += busy_at[m];
    checkOutput("scan1_busy_cycles", busy_cnt, 36);
    checkOutput("scan1_busy_after_last", busy_at[37], 0);
    checkOutput("scan2_busy_start", busy_at[38], 1);
    checkOutput("addr_hold_oob_w", addr_at[10], 165);
    checkOutput("addr_hold_oob_s", addr_at[21], 735);

    act = 0;
    repeat (4) begin
      @(negedge clk);
      act += int'(tile_rd) + int'(step_valid) + int'(busy);
    end
    checkOutput("no_activity_in_reset", act, 0);

    // Scan 3 with walls under ghost 0 W, ghost 1 S/D and ghost 3 A.
    set_ghost(0, 100, 100);
    wall_map[133] = 1'b1;
    wall_map[0]   = 1'b1;
    wall_map[334] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_release", all_outputs(), 0);
    $display("[TB] scan 3: walled map after reset");
    applyStimulus(38, 64'd0, -1, -1);
    exp_rm = '{1, 3, 5, 7, 12, 16, 19, 23, 28, 30, 32, 34};
    exp_ra = '{133, 165, 164, 165, 0, 0, 735, 766, 303, 335, 334, 335};
    exp_sm = '{9, 18, 27, 36};
    exp_sg = '{0, 1, 2, 3};
    exp_sk = '{14, 0, 5, 11};
    exp_ov.delete();
    check_logs("scan3");
    checkOutput("scan3_busy_after_last", busy_at[37], 0);
    checkOutput("scan3_mask_hold", int'(step_movable), 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
